// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback port arbiter.
// XZR address, grant encoding and starve counter width.
package wb_pkg;

  localparam logic [4:0] XZR_ADDR = 5'd31;
  localparam int         STARVE_W = 4;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_A,
    GNT_B
  } grant_t;

endpackage

// File: rtl/wb_starve_cnt.sv
// Saturating starvation counter; clr beats inc, sat when cnt == LIMIT.
// Ports: clk, rst (async active-low), inc, clr, sat.
module wb_starve_cnt
  import wb_pkg::*;
#(
  parameter int LIMIT = 3,
  parameter int W     = STARVE_W
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  logic [W-1:0] cnt;

  assign sat = (cnt == W'(LIMIT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Regfile write-port arbiter: B (load) has priority, A forced on starve.
// Ports: clk, rst (async active-low), a_*/b_* valid/ready requests,
// registered wr_en/wr_addr/wr_data, stall_a to hazard unit.
// Define WB_BYPASS_EN to add combinational fwd_valid/fwd_addr/fwd_data.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int DW         = 64,
  parameter int AW         = 5,
  parameter int STARVE_MAX = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_valid,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_data,
  output logic          a_ready,
  input  logic          b_valid,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_data,
  output logic          b_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
`ifdef WB_BYPASS_EN
  output logic          fwd_valid,
  output logic [AW-1:0] fwd_addr,
  output logic [DW-1:0] fwd_data,
`endif
  output logic          stall_a
);

  localparam logic [AW-1:0] ZR = AW'(XZR_ADDR);

  grant_t        gnt_d;
  grant_t        gnt_q;
  logic          sat;
  logic          xfer;
  logic          wr_en_d;
  logic          wr_en_q;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;

  wb_starve_cnt #(
    .LIMIT (STARVE_MAX),
    .W     (STARVE_W)
  ) u_starve (
    .clk (clk),
    .rst (rst),
    .inc (a_valid & ~a_ready),
    .clr (~a_valid | a_ready),
    .sat (sat)
  );

  // Grant items are kept mutually exclusive; readies stay low in reset.
  always_comb begin
    gnt_d    = GNT_NONE;
    sel_addr = '0;
    sel_data = '0;
    if (rst) begin
      unique case (1'b1)
        (a_valid && b_valid && sat):   gnt_d = GNT_A;
        (b_valid && !(a_valid && sat)): gnt_d = GNT_B;
        (a_valid && !b_valid):         gnt_d = GNT_A;
        default:                       gnt_d = GNT_NONE;
      endcase
    end
    unique case (gnt_d)
      GNT_A: begin
        sel_addr = a_addr;
        sel_data = a_data;
      end
      GNT_B: begin
        sel_addr = b_addr;
        sel_data = b_data;
      end
      default: ;
    endcase
  end

  assign a_ready = (gnt_d == GNT_A);
  assign b_ready = (gnt_d == GNT_B);
  assign stall_a = a_valid & ~a_ready;
  assign xfer    = (gnt_d != GNT_NONE);
  assign wr_en_d = xfer && (sel_addr != ZR);

`ifdef WB_BYPASS_EN
  assign fwd_valid = wr_en_d;
  assign fwd_addr  = sel_addr;
  assign fwd_data  = sel_data;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_q   <= GNT_NONE;
      wr_en_q <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      gnt_q   <= gnt_d;
      wr_en_q <= wr_en_d;
      if (xfer) begin
        wr_addr <= sel_addr;
        wr_data <= sel_data;
      end
    end
  end

  assign wr_en = wr_en_q & (gnt_q != GNT_NONE);

  // Requesters must hold valid/addr/data until accepted.
  a_hold: assert property (@(posedge clk) disable iff (!rst)
    (a_valid && !a_ready) |=>
      (a_valid && $stable(a_addr) && $stable(a_data)));

  b_hold: assert property (@(posedge clk) disable iff (!rst)
    (b_valid && !b_ready) |=>
      (b_valid && $stable(b_addr) && $stable(b_data)));

  one_gnt: assert property (@(posedge clk)
    !(a_ready && b_ready));

endmodule
